fifo_wr_arbiter: RTL

//  Round-robin, packet-locked arbiter that shares the single write port of the

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the single packet-fifo write port
// among NREQ sources, with fifo backpressure and a stalled-owner watchdog.
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DSIZE   = 16,
  parameter int TIMEOUT = 8,
  parameter int CNTW    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           src_valid,
  input  logic [NREQ-1:0]           src_last,
  input  logic [NREQ*DSIZE-1:0]     src_data,
  output logic [NREQ-1:0]           src_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wreq,
  output logic [DSIZE-1:0]          fifo_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      abort,
  output logic [$clog2(NREQ)-1:0]   abort_id,
  output logic [CNTW-1:0]           pkt_words,
  output logic                      pkt_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gidx;
  logic [CNTW-1:0] beat_cnt;
  logic [WDW-1:0]  wd_cnt;

  logic [IDW-1:0]  pick;
  logic            pick_found;
  logic [IDW-1:0]  cand;
  logic            own_valid;
  logic            own_last;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating search starting just after the last owner.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && src_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign own_valid = src_valid[gidx];
  assign own_last  = src_last[gidx];

  assign src_ready = gnt & {NREQ{~fifo_full & ~rst}};
  assign fifo_wreq = |(src_valid & src_ready);

  // AND-OR mux keeps the write data at zero while nobody owns the port.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_wdata = fifo_wdata | src_data[i*DSIZE +: DSIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
      busy      <= 1'b0;
      abort     <= 1'b0;
      abort_id  <= '0;
      pkt_words <= '0;
      pkt_done  <= 1'b0;
      beat_cnt  <= '0;
      wd_cnt    <= '0;
    end else begin
      abort    <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt      <= onehot(pick);
            gidx     <= pick;
            busy     <= 1'b1;
            beat_cnt <= '0;
            wd_cnt   <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (own_valid) begin
            // A full fifo stalls the owner without advancing the watchdog.
            if (!fifo_full) begin
              wd_cnt <= '0;
              if (own_last) begin
                pkt_words <= sat_inc(beat_cnt);
                pkt_done  <= 1'b1;
                beat_cnt  <= '0;
                rr_ptr    <= gidx;
                gnt       <= '0;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end else begin
                beat_cnt <= sat_inc(beat_cnt);
              end
            end
          end else if (wd_cnt == WD_LAST) begin
            abort    <= 1'b1;
            abort_id <= gidx;
            rr_ptr   <= gidx;
            gnt      <= '0;
            beat_cnt <= '0;
            wd_cnt   <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
